// File: rtl/delay_monitor.sv
// Receive-side watchdog for the periodic delay pulse: measures the spacing between
// consecutive single-cycle pulses on sig and reports good/early/late, lock and error count.
module delay_monitor #(
  parameter int N        = 22500,
  parameter int CBITS    = 15,
  parameter int TOL      = 4,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  output logic       pulse_ok,
  output logic       err_early,
  output logic       err_late,
  output logic       locked,
  output logic [7:0] err_cnt
);

  // gap holds spacing-1, so the window edges are expressed one below the spacing bounds
  localparam logic [CBITS-1:0] GAP_MIN  = CBITS'(N - TOL);
  localparam logic [CBITS-1:0] GAP_MAX  = CBITS'(N + TOL);
  localparam int               GBITS    = $clog2(LOCK_CNT + 1);
  localparam logic [GBITS-1:0] GOOD_MAX = GBITS'(LOCK_CNT);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [CBITS-1:0]   gap_r, gap_s;
  logic [GBITS-1:0]   good_r, good_s;
  logic               pulse_ok_s, err_early_s, err_late_s, locked_s;
  logic [7:0]         err_cnt_s;

  // Next-state, gap/good bookkeeping and next values of every registered output
  always_comb begin
    state_s     = state_r;
    gap_s       = gap_r;
    good_s      = good_r;
    pulse_ok_s  = 1'b0;
    err_early_s = 1'b0;
    err_late_s  = 1'b0;
    locked_s    = locked;
    err_cnt_s   = err_cnt;

    case (state_r)
      HUNT: begin
        gap_s    = '0;
        locked_s = 1'b0;
        if (sig) begin
          state_s = TRACK;
        end else begin
          state_s = HUNT;
        end
      end

      TRACK: begin
        if (sig) begin
          gap_s = '0;
          if (gap_r < GAP_MIN) begin
            // early pulse becomes the new reference
            err_early_s = 1'b1;
            good_s      = '0;
            locked_s    = 1'b0;
          end else begin
            pulse_ok_s = 1'b1;
            if (good_r < GOOD_MAX) begin
              good_s = good_r + GBITS'(1);
            end else begin
              good_s = good_r;
            end
            locked_s = (good_s == GOOD_MAX);
          end
        end else if (gap_r >= GAP_MAX) begin
          err_late_s = 1'b1;
          good_s     = '0;
          locked_s   = 1'b0;
          gap_s      = '0;
          state_s    = HUNT;
        end else begin
          gap_s = gap_r + CBITS'(1);
        end
      end

      default: begin
        state_s  = HUNT;
        gap_s    = '0;
        good_s   = '0;
        locked_s = 1'b0;
      end
    endcase

    if ((err_early_s || err_late_s) && (err_cnt != 8'hFF)) begin
      err_cnt_s = err_cnt + 8'd1;
    end else begin
      err_cnt_s = err_cnt;
    end
  end

  // State, counters and all outputs are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= HUNT;
      gap_r     <= '0;
      good_r    <= '0;
      pulse_ok  <= 1'b0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      state_r   <= state_s;
      gap_r     <= gap_s;
      good_r    <= good_s;
      pulse_ok  <= pulse_ok_s;
      err_early <= err_early_s;
      err_late  <= err_late_s;
      locked    <= locked_s;
      err_cnt   <= err_cnt_s;
    end
  end

endmodule

// File: tb/tb_delay_monitor.sv
// Directed bench for delay_monitor with N=10, TOL=1, LOCK_CNT=3 (good spacing 10..12).
module tb_delay_monitor;

  logic       clk;
  logic       rst;
  logic       sig;
  logic       pulse_ok;
  logic       err_early;
  logic       err_late;
  logic       locked;
  logic [7:0] err_cnt;

  int n_cmp;
  int n_err;

  delay_monitor #(
    .N        (10),
    .CBITS    (5),
    .TOL      (1),
    .LOCK_CNT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig       (sig),
    .pulse_ok  (pulse_ok),
    .err_early (err_early),
    .err_late  (err_late),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present sig for one sampling edge; outputs are then the result of that edge
  task automatic step(input logic s);
    sig = s;
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, pulse_ok, err_early, err_late}, {29'd0, exp});
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      strobes("quiet", 3'b000);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    sig   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    strobes("rst_strobes", 3'b000);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;

    // five pulses at spacing 11: reference, then four good; locked after the 4th
    step(1'b1);
    strobes("first_ref", 3'b000);
    for (int p = 2; p <= 5; p++) begin
      zeros(10);
      step(1'b1);
      strobes("lock_ok", 3'b100);
      chk("lock_lvl", {31'd0, locked}, (p >= 4) ? 32'd1 : 32'd0);
      chk("lock_errcnt", {24'd0, err_cnt}, 32'd0);
    end

    // spacing 9 is early; next pulse measured from the early one
    zeros(8);
    step(1'b1);
    strobes("early9", 3'b010);
    chk("early9_locked", {31'd0, locked}, 32'd0);
    chk("early9_errcnt", {24'd0, err_cnt}, 32'd1);
    zeros(10);
    step(1'b1);
    strobes("after_early_ok", 3'b100);

    // window edges 10 and 12 are good (relocks at good=3)
    zeros(9);
    step(1'b1);
    strobes("spacing10", 3'b100);
    zeros(11);
    step(1'b1);
    strobes("spacing12", 3'b100);
    chk("spacing12_locked", {31'd0, locked}, 32'd1);

    // spacing 13: late fires at gap 11, then the pulse only re-references
    zeros(11);
    step(1'b0);
    strobes("late", 3'b001);
    chk("late_locked", {31'd0, locked}, 32'd0);
    chk("late_errcnt", {24'd0, err_cnt}, 32'd2);
    step(1'b1);
    strobes("late_reref", 3'b000);

    // sig held high three cycles: good, then two early
    zeros(10);
    step(1'b1);
    strobes("hold_1st", 3'b100);
    step(1'b1);
    strobes("hold_2nd", 3'b010);
    chk("hold_2nd_cnt", {24'd0, err_cnt}, 32'd3);
    step(1'b1);
    strobes("hold_3rd", 3'b010);
    chk("hold_3rd_cnt", {24'd0, err_cnt}, 32'd4);
    step(1'b0);
    strobes("hold_release", 3'b000);

    // relock, then asynchronous reset clears outputs before the next edge
    zeros(9);
    step(1'b1);
    strobes("relock1", 3'b100);
    for (int k = 0; k < 2; k++) begin
      zeros(10);
      step(1'b1);
      strobes("relock", 3'b100);
    end
    chk("relock_locked", {31'd0, locked}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    strobes("arst_strobes", 3'b000);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_errcnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1);
    strobes("post_rst_ref", 3'b000);
    zeros(10);
    step(1'b1);
    strobes("post_rst_ok", 3'b100);

    // 300 back-to-back early pulses: err_cnt saturates at 255
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      if (i == 253) chk("sat_254", {24'd0, err_cnt}, 32'd254);
      if (i == 254) chk("sat_255", {24'd0, err_cnt}, 32'd255);
    end
    strobes("sat_early", 3'b010);
    chk("sat_final", {24'd0, err_cnt}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
